// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline.
// Holds the ID->EX, EX->MEM and MEM->WB control/PC registers, detects
// read-after-write hazards against the ID-stage instruction, and produces
// stall, flush and operand-forwarding decisions plus stall/flush counters.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_id_*                  ID-stage instruction (valid, rs1, rs2, rd, reg_wr,
//                           is_load, pc, pc_next)
//   i_ex_redirect           EX resolved a taken branch/jump
//   o_stall_if/o_stall_id   hold PC and IF/ID register (combinational)
//   o_flush_id              clear IF/ID register (combinational)
//   o_fwd_a_sel/o_fwd_b_sel EX operand source: 00 regfile, 01 MEM, 10 WB
//   o_ex/mem/wb_valid       stage valid bits
//   o_ex_pc, o_wb_pc_next   EX PC and WB PC+4
//   o_wb_rd, o_wb_reg_wr    regfile write address / enable
//   o_stall_cnt/o_flush_cnt saturating performance counters
module pipeline_hazard_ctrl #(
    parameter int unsigned PC_WIDTH       = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned FWD_EN         = 1,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rd,
    input  logic                      i_id_reg_wr,
    input  logic                      i_id_is_load,
    input  logic [PC_WIDTH-1:0]       i_id_pc,
    input  logic [PC_WIDTH-1:0]       i_id_pc_next,
    input  logic                      i_ex_redirect,
    output logic                      o_stall_if,
    output logic                      o_stall_id,
    output logic                      o_flush_id,
    output logic [1:0]                o_fwd_a_sel,
    output logic [1:0]                o_fwd_b_sel,
    output logic                      o_ex_valid,
    output logic                      o_mem_valid,
    output logic                      o_wb_valid,
    output logic [PC_WIDTH-1:0]       o_ex_pc,
    output logic [PC_WIDTH-1:0]       o_wb_pc_next,
    output logic [REG_ADDR_WIDTH-1:0] o_wb_rd,
    output logic                      o_wb_reg_wr,
    output logic [CNT_WIDTH-1:0]      o_stall_cnt,
    output logic [CNT_WIDTH-1:0]      o_flush_cnt
);

    localparam logic [1:0]           SEL_RF  = 2'b00;
    localparam logic [1:0]           SEL_MEM = 2'b01;
    localparam logic [1:0]           SEL_WB  = 2'b10;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_wr;
        logic                      is_load;
        logic [PC_WIDTH-1:0]       pc;
        logic [PC_WIDTH-1:0]       pc_next;
    } stage_t;

    typedef struct packed {
        stage_t                    st;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
    } idex_t;

    idex_t  ex_q;
    idex_t  ex_d;
    stage_t mem_q;
    stage_t wb_q;

    logic hz_ex;
    logic hz_mem;
    logic stall_raw;
    logic redirect;
    logic stall;

    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;

    // True when a valid stage writes a non-x0 register equal to r.
    function automatic logic writes_reg(input stage_t s, input logic [REG_ADDR_WIDTH-1:0] r);
        return s.valid && s.reg_wr && (s.rd != '0) && (s.rd == r);
    endfunction

    // Operand source for one EX read port; MEM beats WB, loads in MEM cannot forward.
    function automatic logic [1:0] fwd_sel(input logic ex_valid, input stage_t mem,
                                           input stage_t wb,
                                           input logic [REG_ADDR_WIDTH-1:0] rs);
        logic [1:0] sel;
        sel = SEL_RF;
        if (FWD_EN != 0 && ex_valid) begin
            if (writes_reg(mem, rs) && !mem.is_load) begin
                sel = SEL_MEM;
            end else if (writes_reg(wb, rs)) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    // Hazard detection, stall/redirect arbitration and ID->EX next value.
    always_comb begin
        hz_ex     = i_id_valid && (writes_reg(ex_q.st, i_id_rs1) || writes_reg(ex_q.st, i_id_rs2));
        hz_mem    = i_id_valid && (writes_reg(mem_q, i_id_rs1) || writes_reg(mem_q, i_id_rs2));
        stall_raw = (FWD_EN != 0) ? (hz_ex && ex_q.st.is_load) : (hz_ex || hz_mem);
        redirect  = i_ex_redirect && ex_q.st.valid;
        // A taken redirect kills the ID instruction, so any stall on it is moot.
        stall     = stall_raw && !redirect;

        ex_d = '0;
        if (!(stall || redirect)) begin
            ex_d.st.valid   = i_id_valid;
            ex_d.st.rd      = i_id_rd;
            ex_d.st.reg_wr  = i_id_reg_wr;
            ex_d.st.is_load = i_id_is_load;
            ex_d.st.pc      = i_id_pc;
            ex_d.st.pc_next = i_id_pc_next;
            ex_d.rs1        = i_id_rs1;
            ex_d.rs2        = i_id_rs2;
        end
    end

    // Pipeline registers; EX->MEM and MEM->WB always advance.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q.st;
            wb_q  <= mem_q;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
            if (redirect && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // WB PC and load flag are carried for completeness but not consumed here.
    logic unused_wb_bits;
    assign unused_wb_bits = ^{wb_q.pc, wb_q.is_load};

    assign o_stall_if   = stall;
    assign o_stall_id   = stall;
    assign o_flush_id   = redirect;
    assign o_fwd_a_sel  = fwd_sel(ex_q.st.valid, mem_q, wb_q, ex_q.rs1);
    assign o_fwd_b_sel  = fwd_sel(ex_q.st.valid, mem_q, wb_q, ex_q.rs2);
    assign o_ex_valid   = ex_q.st.valid;
    assign o_mem_valid  = mem_q.valid;
    assign o_wb_valid   = wb_q.valid;
    assign o_ex_pc      = ex_q.st.pc;
    assign o_wb_pc_next = wb_q.pc_next;
    assign o_wb_rd      = wb_q.rd;
    assign o_wb_reg_wr  = wb_q.valid && wb_q.reg_wr;
    assign o_stall_cnt  = stall_cnt_q;
    assign o_flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances (forwarding, no forwarding,
// 4-bit counters) share one stimulus stream and are each compared every cycle
// against an instruction-level model, plus a directed vector table and
// hand-written multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        id_valid;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_wr, is_load;
    logic [31:0] pc, pc_next;
    logic        redirect;

    logic        stall_if [3];
    logic        stall_id [3];
    logic        flush    [3];
    logic [1:0]  fa       [3];
    logic [1:0]  fb       [3];
    logic        exv      [3];
    logic        memv     [3];
    logic        wbv      [3];
    logic [31:0] ex_pc    [3];
    logic [31:0] wb_pcn   [3];
    logic [4:0]  wb_rd    [3];
    logic        wb_wr    [3];
    logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
    logic [3:0]  scnt_c, fcnt_c;

    pipeline_hazard_ctrl u_fwd (
        .i_clk(clk), .i_reset(reset), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
        .i_id_rd(rd), .i_id_reg_wr(reg_wr), .i_id_is_load(is_load), .i_id_pc(pc),
        .i_id_pc_next(pc_next), .i_ex_redirect(redirect), .o_stall_if(stall_if[0]),
        .o_stall_id(stall_id[0]), .o_flush_id(flush[0]), .o_fwd_a_sel(fa[0]), .o_fwd_b_sel(fb[0]),
        .o_ex_valid(exv[0]), .o_mem_valid(memv[0]), .o_wb_valid(wbv[0]), .o_ex_pc(ex_pc[0]),
        .o_wb_pc_next(wb_pcn[0]), .o_wb_rd(wb_rd[0]), .o_wb_reg_wr(wb_wr[0]),
        .o_stall_cnt(scnt_a), .o_flush_cnt(fcnt_a));

    pipeline_hazard_ctrl #(.FWD_EN(0)) u_nofwd (
        .i_clk(clk), .i_reset(reset), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
        .i_id_rd(rd), .i_id_reg_wr(reg_wr), .i_id_is_load(is_load), .i_id_pc(pc),
        .i_id_pc_next(pc_next), .i_ex_redirect(redirect), .o_stall_if(stall_if[1]),
        .o_stall_id(stall_id[1]), .o_flush_id(flush[1]), .o_fwd_a_sel(fa[1]), .o_fwd_b_sel(fb[1]),
        .o_ex_valid(exv[1]), .o_mem_valid(memv[1]), .o_wb_valid(wbv[1]), .o_ex_pc(ex_pc[1]),
        .o_wb_pc_next(wb_pcn[1]), .o_wb_rd(wb_rd[1]), .o_wb_reg_wr(wb_wr[1]),
        .o_stall_cnt(scnt_b), .o_flush_cnt(fcnt_b));

    pipeline_hazard_ctrl #(.CNT_WIDTH(4)) u_cnt4 (
        .i_clk(clk), .i_reset(reset), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
        .i_id_rd(rd), .i_id_reg_wr(reg_wr), .i_id_is_load(is_load), .i_id_pc(pc),
        .i_id_pc_next(pc_next), .i_ex_redirect(redirect), .o_stall_if(stall_if[2]),
        .o_stall_id(stall_id[2]), .o_flush_id(flush[2]), .o_fwd_a_sel(fa[2]), .o_fwd_b_sel(fb[2]),
        .o_ex_valid(exv[2]), .o_mem_valid(memv[2]), .o_wb_valid(wbv[2]), .o_ex_pc(ex_pc[2]),
        .o_wb_pc_next(wb_pcn[2]), .o_wb_rd(wb_rd[2]), .o_wb_reg_wr(wb_wr[2]),
        .o_stall_cnt(scnt_c), .o_flush_cnt(fcnt_c));

    localparam bit          FWDK [3] = '{1'b1, 1'b0, 1'b1};
    localparam logic [63:0] CMAX [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hF};

    int errors = 0;
    int checks = 0;
    bit model_on = 1'b0;

    // One in-flight instruction as the model sees it.
    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic        wr;
        logic        ld;
        logic [31:0] pc;
        logic [31:0] pcn;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } ins_t;

    // pipe[k][0]=EX, [1]=MEM, [2]=WB for instance k.
    ins_t        pipe   [3][3];
    ins_t        pipe_n [3][3];
    logic [63:0] mscnt [3], mfcnt [3], mscnt_n [3], mfcnt_n [3];

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dut_scnt(input int k);
        case (k)
            0:       return 64'(scnt_a);
            1:       return 64'(scnt_b);
            default: return 64'(scnt_c);
        endcase
    endfunction

    function automatic logic [63:0] dut_fcnt(input int k);
        case (k)
            0:       return 64'(fcnt_a);
            1:       return 64'(fcnt_b);
            default: return 64'(fcnt_c);
        endcase
    endfunction

    function automatic bit hit(input ins_t p, input logic [4:0] r);
        return p.v && p.wr && (p.rd != 5'd0) && (p.rd == r);
    endfunction

    function automatic logic [1:0] exp_sel(input bit fen, input ins_t ex, input ins_t mem,
                                           input ins_t wb, input logic [4:0] r);
        if (!fen || !ex.v) return 2'd0;
        if (hit(mem, r) && !mem.ld) return 2'd1;
        if (hit(wb, r)) return 2'd2;
        return 2'd0;
    endfunction

    // Compare all instances against the model and compute the model's next state.
    task automatic model_eval();
        for (int k = 0; k < 3; k++) begin
            ins_t ex, mem, wb, nx;
            bit hz_ex, hz_mem, raw, redir, stl;
            ex  = pipe[k][0];
            mem = pipe[k][1];
            wb  = pipe[k][2];
            hz_ex  = id_valid && (hit(ex, rs1) || hit(ex, rs2));
            hz_mem = id_valid && (hit(mem, rs1) || hit(mem, rs2));
            raw    = FWDK[k] ? (hz_ex && ex.ld) : (hz_ex || hz_mem);
            redir  = redirect && ex.v;
            stl    = raw && !redir;
            if (model_on) begin
                chk("stall_if", k, 64'(stall_if[k]), 64'(stl));
                chk("stall_id", k, 64'(stall_id[k]), 64'(stl));
                chk("flush_id", k, 64'(flush[k]), 64'(redir));
                chk("fwd_a", k, 64'(fa[k]), 64'(exp_sel(FWDK[k], ex, mem, wb, ex.rs1)));
                chk("fwd_b", k, 64'(fb[k]), 64'(exp_sel(FWDK[k], ex, mem, wb, ex.rs2)));
                chk("ex_valid", k, 64'(exv[k]), 64'(ex.v));
                chk("mem_valid", k, 64'(memv[k]), 64'(mem.v));
                chk("wb_valid", k, 64'(wbv[k]), 64'(wb.v));
                chk("wb_reg_wr", k, 64'(wb_wr[k]), 64'(wb.v && wb.wr));
                if (ex.v) chk("ex_pc", k, 64'(ex_pc[k]), 64'(ex.pc));
                if (wb.v) begin
                    chk("wb_pc_next", k, 64'(wb_pcn[k]), 64'(wb.pcn));
                    chk("wb_rd", k, 64'(wb_rd[k]), 64'(wb.rd));
                end
                chk("stall_cnt", k, dut_scnt(k), mscnt[k]);
                chk("flush_cnt", k, dut_fcnt(k), mfcnt[k]);
            end
            nx = '{default: 0};
            if (!(stl || redir)) begin
                nx = '{v: id_valid, rd: rd, wr: reg_wr, ld: is_load, pc: pc, pcn: pc_next,
                       rs1: rs1, rs2: rs2};
            end
            if (reset) begin
                for (int s = 0; s < 3; s++) pipe_n[k][s] = '{default: 0};
                mscnt_n[k] = 64'd0;
                mfcnt_n[k] = 64'd0;
            end else begin
                pipe_n[k][0] = nx;
                pipe_n[k][1] = ex;
                pipe_n[k][2] = mem;
                mscnt_n[k] = (stl && mscnt[k] != CMAX[k]) ? mscnt[k] + 64'd1 : mscnt[k];
                mfcnt_n[k] = (redir && mfcnt[k] != CMAX[k]) ? mfcnt[k] + 64'd1 : mfcnt[k];
            end
        end
    endtask

    // Called just after a falling edge: compare, take the rising edge, advance.
    task automatic end_cycle();
        model_eval();
        @(posedge clk);
        pipe  = pipe_n;
        mscnt = mscnt_n;
        mfcnt = mfcnt_n;
        #1;
    endtask

    task automatic drv(input logic v, input int a, input int b, input int d,
                       input logic w, input logic l, input logic r);
        id_valid = v;
        rs1      = 5'(a);
        rs2      = 5'(b);
        rd       = 5'(d);
        reg_wr   = w;
        is_load  = l;
        pc       = $urandom;
        pc_next  = pc + 32'd4;
        redirect = r;
    endtask

    task automatic cyc();
        @(negedge clk);
        end_cycle();
    endtask

    task automatic reset_seq();
        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0);
        cyc();
        reset = 1'b0;
    endtask

    typedef struct {
        logic v;
        int   a, b, d;
        logic w, l;
        int   e_stall, e_fa, e_fb;
    } vec_t;
    vec_t tbl [15];

    initial begin
        // Hand-derived program for the forwarding instance.
        tbl[0]  = '{1, 1, 2, 3, 1, 0, 0, 0, 0};  // add x3,x1,x2
        tbl[1]  = '{1, 3, 3, 4, 1, 0, 0, 0, 0};  // sub x4,x3,x3
        tbl[2]  = '{1, 4, 0, 5, 1, 1, 0, 1, 1};  // lw x5,(x4); sub in EX gets 01/01
        tbl[3]  = '{1, 5, 1, 6, 1, 0, 1, 1, 0};  // add x6,x5,x1 load-use stall
        tbl[4]  = '{1, 5, 1, 6, 1, 0, 0, 0, 0};  // held; EX bubble
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 2, 0};  // add in EX forwards from WB
        tbl[6]  = '{1, 0, 0, 7, 1, 0, 0, 0, 0};  // addi x7
        tbl[7]  = '{1, 0, 0, 7, 1, 0, 0, 0, 0};  // addi x7
        tbl[8]  = '{1, 7, 0, 8, 1, 0, 0, 0, 0};  // add x8,x7,x0
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};  // MEM beats WB for x7
        tbl[10] = '{1, 1, 2, 0, 1, 0, 0, 0, 0};  // "write" x0
        tbl[11] = '{1, 0, 0, 9, 1, 0, 0, 0, 0};  // add x9,x0,x0
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};  // x0 in MEM never forwards
        tbl[13] = '{1, 0, 0, 0, 1, 1, 0, 0, 0};  // lw x0
        tbl[14] = '{1, 0, 0, 10, 1, 0, 0, 0, 0}; // read x0 behind lw x0: no stall

        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 3; s++) pipe[k][s] = '{default: 0};
            mscnt[k] = 64'd0;
            mfcnt[k] = 64'd0;
        end

        reset_seq();
        model_on = 1'b1;
        reset_seq();

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            drv(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].w, tbl[i].l, 0);
            @(negedge clk);
            chk($sformatf("tbl%0d_stall", i), 0, 64'(stall_if[0]), 64'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_flush", i), 0, 64'(flush[0]), 64'd0);
            chk($sformatf("tbl%0d_fwd_a", i), 0, 64'(fa[0]), 64'(tbl[i].e_fa));
            chk($sformatf("tbl%0d_fwd_b", i), 0, 64'(fb[0]), 64'(tbl[i].e_fb));
            end_cycle();
        end
        @(negedge clk);
        chk("tbl_stall_cnt", 0, 64'(scnt_a), 64'd1);
        end_cycle();

        // No forwarding: ALU producer followed by consumer stalls twice.
        reset_seq();
        drv(1, 1, 2, 3, 1, 0, 0);
        cyc();
        drv(1, 3, 0, 9, 1, 0, 0);
        @(negedge clk);
        chk("nf_stall1", 1, 64'(stall_if[1]), 64'd1);
        end_cycle();
        @(negedge clk);
        chk("nf_stall2", 1, 64'(stall_if[1]), 64'd1);
        end_cycle();
        @(negedge clk);
        chk("nf_stall3", 1, 64'(stall_if[1]), 64'd0);
        chk("nf_fwd_a", 1, 64'(fa[1]), 64'd0);
        chk("nf_stall_cnt", 1, 64'(scnt_b), 64'd2);
        chk("fw_stall_cnt", 0, 64'(scnt_a), 64'd0);
        end_cycle();

        // Redirect over load-use stall; redirect with empty EX is ignored.
        reset_seq();
        drv(1, 1, 0, 5, 1, 1, 0);
        cyc();
        drv(1, 5, 1, 6, 1, 0, 1);
        @(negedge clk);
        chk("rd_flush", 0, 64'(flush[0]), 64'd1);
        chk("rd_stall", 0, 64'(stall_if[0]), 64'd0);
        end_cycle();
        drv(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("rd_ex_bubble", 0, 64'(exv[0]), 64'd0);
        chk("rd_no_flush", 0, 64'(flush[0]), 64'd0);
        chk("rd_flush_cnt", 0, 64'(fcnt_a), 64'd1);
        chk("rd_stall_cnt", 0, 64'(scnt_a), 64'd0);
        end_cycle();

        // Reset asserted in the middle of a stall.
        reset_seq();
        drv(1, 1, 0, 5, 1, 1, 0);
        cyc();
        drv(1, 5, 1, 6, 1, 0, 0);
        cyc();
        cyc();
        drv(1, 1, 0, 5, 1, 1, 0);
        cyc();
        drv(1, 5, 1, 6, 1, 0, 0);
        @(negedge clk);
        chk("mid_stall", 0, 64'(stall_if[0]), 64'd1);
        chk("mid_cnt", 0, 64'(scnt_a), 64'd1);
        reset = 1'b1;
        end_cycle();
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_valids", 0, 64'({exv[0], memv[0], wbv[0]}), 64'd0);
        chk("rst_stall_cnt", 0, 64'(scnt_a), 64'd0);
        chk("rst_stall", 0, 64'(stall_if[0]), 64'd0);
        chk("rst_wb_wr", 0, 64'(wb_wr[0]), 64'd0);
        end_cycle();

        // 20 load-use stalls: 4-bit counter saturates at 15.
        reset_seq();
        for (int i = 0; i < 20; i++) begin
            drv(1, 1, 0, 5, 1, 1, 0);
            cyc();
            drv(1, 5, 1, 6, 1, 0, 0);
            cyc();
            cyc();
        end
        @(negedge clk);
        chk("sat_cnt4", 2, 64'(scnt_c), 64'd15);
        chk("sat_cnt32", 0, 64'(scnt_a), 64'd20);
        end_cycle();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            drv(($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
